// File: rtl/sc_intr_ctrl.sv
// rtl/sc_intr_ctrl.sv - fixed-priority interrupt controller with edge capture and a single intr/inta/eoi handshake
module sc_intr_ctrl #(
    parameter int NSRC = 8,
    parameter int IDW  = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NSRC-1:0] irq_i,
    input  logic            ien_we_i,
    input  logic [NSRC-1:0] ien_wdata_i,
    output logic [NSRC-1:0] ien_o,
    output logic [NSRC-1:0] pending_o,
    output logic            intr_o,
    input  logic            inta_i,
    output logic [IDW-1:0]  int_id_o,
    input  logic            eoi_i,
    output logic            in_service_o,
    output logic [15:0]     ack_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERV
    } state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] ien_q, ien_d;
    logic            intr_q, intr_d;
    logic [IDW-1:0]  int_id_q, int_id_d;
    logic            in_service_q, in_service_d;
    logic [15:0]     ack_cnt_q, ack_cnt_d;

    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] clr;
    logic [IDW-1:0]  winner;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            irq_q        <= '0;
            pending_q    <= '0;
            ien_q        <= '0;
            intr_q       <= 1'b0;
            int_id_q     <= '0;
            in_service_q <= 1'b0;
            ack_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_i;
            pending_q    <= pending_d;
            ien_q        <= ien_d;
            intr_q       <= intr_d;
            int_id_q     <= int_id_d;
            in_service_q <= in_service_d;
            ack_cnt_q    <= ack_cnt_d;
        end
    end

    always_comb begin
        eligible     = pending_q & ien_q;
        winner       = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = IDW'(i);
        end

        state_d      = state_q;
        intr_d       = intr_q;
        int_id_d     = int_id_q;
        in_service_d = in_service_q;
        ack_cnt_d    = ack_cnt_q;
        clr          = '0;

        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    int_id_d = winner;
                    intr_d   = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // Withdrawn enable beats a simultaneous acknowledge.
                if (!ien_q[int_id_q]) begin
                    intr_d  = 1'b0;
                    state_d = IDLE;
                end else if (inta_i) begin
                    clr[int_id_q] = 1'b1;
                    intr_d        = 1'b0;
                    in_service_d  = 1'b1;
                    ack_cnt_d     = ack_cnt_q + 16'd1;
                    state_d       = SERV;
                end
            end
            SERV: begin
                if (eoi_i) begin
                    in_service_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh edge on a bit being acknowledged keeps it pending.
        pending_d = (pending_q & ~clr) | (irq_i & ~irq_q);
        ien_d     = ien_we_i ? ien_wdata_i : ien_q;
    end

    assign ien_o        = ien_q;
    assign pending_o    = pending_q;
    assign intr_o       = intr_q;
    assign int_id_o     = int_id_q;
    assign in_service_o = in_service_q;
    assign ack_cnt_o    = ack_cnt_q;

endmodule

// File: tb/tb_sc_intr_ctrl.sv
// tb/tb_sc_intr_ctrl.sv - directed bench for sc_intr_ctrl with an expected-id scoreboard
module tb_sc_intr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    logic        ien_we;
    logic [7:0]  ien_wdata;
    logic [7:0]  ien;
    logic [7:0]  pending;
    logic        intr;
    logic        inta;
    logic [2:0]  int_id;
    logic        eoi;
    logic        in_service;
    logic [15:0] ack_cnt;

    int vectors = 0;
    int miscompares = 0;
    int exp_ack = 0;
    int exp_id_q[$];

    sc_intr_ctrl #(.NSRC(8), .IDW(3)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .irq_i        (irq),
        .ien_we_i     (ien_we),
        .ien_wdata_i  (ien_wdata),
        .ien_o        (ien),
        .pending_o    (pending),
        .intr_o       (intr),
        .inta_i       (inta),
        .int_id_o     (int_id),
        .eoi_i        (eoi),
        .in_service_o (in_service),
        .ack_cnt_o    (ack_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_ien(input logic [7:0] v);
        ien_we = 1'b1;
        ien_wdata = v;
        tick();
        ien_we = 1'b0;
    endtask

    task automatic pulse_irq(input logic [7:0] v);
        irq = v;
        tick();
        irq = 8'h00;
    endtask

    // Waits (bounded) for intr, then pops the scoreboard and compares int_id.
    task automatic present(input string tag);
        int exp_id;
        for (int i = 0; i < 8 && intr !== 1'b1; i++) tick();
        chk({tag, "_intr"}, {31'd0, intr}, 32'd1);
        vectors++;
        assert (exp_id_q.size() > 0) else begin
            miscompares++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (exp_id_q.size() > 0) begin
            exp_id = exp_id_q.pop_front();
            chk({tag, "_id"}, {29'd0, int_id}, exp_id);
        end
    endtask

    task automatic serve();
        inta = 1'b1;
        tick();
        inta = 1'b0;
        exp_ack++;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq = 8'h00; ien_we = 1'b0; ien_wdata = 8'h00; inta = 1'b0; eoi = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_ien", {24'd0, ien}, 32'h0);
        chk("rst_pending", {24'd0, pending}, 32'h0);
        chk("rst_intr", {31'd0, intr}, 32'h0);
        chk("rst_int_id", {29'd0, int_id}, 32'h0);
        chk("rst_in_service", {31'd0, in_service}, 32'h0);
        chk("rst_ack_cnt", {16'd0, ack_cnt}, 32'h0);

        // 1: single source, exact latency, ack and eoi
        write_ien(8'hFF);
        chk("t1_ien", {24'd0, ien}, 32'hFF);
        exp_id_q.push_back(3);
        pulse_irq(8'h08);
        chk("t1_pending", {24'd0, pending}, 32'h08);
        chk("t1_intr_early", {31'd0, intr}, 32'h0);
        tick();
        chk("t1_intr_lat", {31'd0, intr}, 32'h1);
        present("t1");
        inta = 1'b1; tick(); inta = 1'b0; exp_ack++;
        chk("t1_pend_clr", {24'd0, pending}, 32'h0);
        chk("t1_in_service", {31'd0, in_service}, 32'h1);
        chk("t1_ack_cnt", {16'd0, ack_cnt}, exp_ack);
        chk("t1_intr_low", {31'd0, intr}, 32'h0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("t1_eoi_is", {31'd0, in_service}, 32'h0);
        tick();
        chk("t1_idle_intr", {31'd0, intr}, 32'h0);

        // 2: simultaneous sources, lowest index first
        exp_id_q.push_back(2);
        exp_id_q.push_back(5);
        pulse_irq(8'h24);
        tick();
        present("t2a");
        inta = 1'b1; tick(); inta = 1'b0; exp_ack++;
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("t2_after_eoi", {31'd0, intr}, 32'h0);
        tick();
        chk("t2_next_lat", {31'd0, intr}, 32'h1);
        present("t2b");
        serve();

        // 3: masked capture, later enable
        write_ien(8'h00);
        pulse_irq(8'h02);
        chk("t3_pending", {24'd0, pending}, 32'h02);
        tick();
        chk("t3_masked", {31'd0, intr}, 32'h0);
        exp_id_q.push_back(1);
        write_ien(8'h02);
        tick();
        present("t3");
        serve();
        chk("t3_ack_cnt", {16'd0, ack_cnt}, exp_ack);

        // 4: enable withdrawn while requesting
        write_ien(8'hFF);
        exp_id_q.push_back(4);
        pulse_irq(8'h10);
        tick();
        present("t4");
        write_ien(8'h00);
        tick();
        chk("t4_drop", {31'd0, intr}, 32'h0);
        chk("t4_pending", {24'd0, pending}, 32'h10);
        inta = 1'b1; tick(); inta = 1'b0;
        chk("t4_ack_cnt", {16'd0, ack_cnt}, exp_ack);
        chk("t4_in_service", {31'd0, in_service}, 32'h0);
        exp_id_q.push_back(4);
        write_ien(8'hFF);
        present("t4r");
        serve();

        // 5: new edge in SERV alongside a stray inta
        exp_id_q.push_back(0);
        pulse_irq(8'h01);
        present("t5");
        inta = 1'b1; tick(); inta = 1'b0; exp_ack++;
        irq = 8'h01; inta = 1'b1; tick(); irq = 8'h00; inta = 1'b0;
        chk("t5_pending", {24'd0, pending}, 32'h01);
        chk("t5_in_service", {31'd0, in_service}, 32'h1);
        chk("t5_ack_cnt", {16'd0, ack_cnt}, exp_ack);
        exp_id_q.push_back(0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        present("t5r");
        serve();

        // same-cycle acknowledge and fresh edge on the same bit: set wins
        exp_id_q.push_back(2);
        pulse_irq(8'h04);
        present("tc");
        irq = 8'h04; inta = 1'b1; tick(); irq = 8'h00; inta = 1'b0; exp_ack++;
        chk("tc_pending", {24'd0, pending}, 32'h04);
        chk("tc_in_service", {31'd0, in_service}, 32'h1);
        exp_id_q.push_back(2);
        eoi = 1'b1; tick(); eoi = 1'b0;
        present("tcr");
        serve();
        chk("tc_ack_cnt", {16'd0, ack_cnt}, exp_ack);

        // 6: counter wrap, then reset while requesting
        force dut.ack_cnt_q = 16'hFFFF;
        #1;
        release dut.ack_cnt_q;
        chk("t6_preload", {16'd0, ack_cnt}, 32'hFFFF);
        exp_id_q.push_back(3);
        pulse_irq(8'h08);
        present("t6");
        inta = 1'b1; tick(); inta = 1'b0;
        chk("t6_wrap", {16'd0, ack_cnt}, 32'h0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        exp_id_q.push_back(6);
        pulse_irq(8'h40);
        present("t6b");
        rst = 1'b1; irq = 8'h80; tick(); rst = 1'b0;
        chk("t6_rst_ien", {24'd0, ien}, 32'h0);
        chk("t6_rst_pending", {24'd0, pending}, 32'h0);
        chk("t6_rst_intr", {31'd0, intr}, 32'h0);
        chk("t6_rst_int_id", {29'd0, int_id}, 32'h0);
        chk("t6_rst_in_service", {31'd0, in_service}, 32'h0);
        chk("t6_rst_ack_cnt", {16'd0, ack_cnt}, 32'h0);
        tick();
        chk("t6_held_edge", {24'd0, pending}, 32'h80);
        tick();
        chk("t6_held_once", {24'd0, pending}, 32'h80);
        chk("t6_masked", {31'd0, intr}, 32'h0);
        chk("sb_empty", exp_id_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
